// File: rtl/tick_gen_prog.sv
// Programmable oversampling tick generator: fast strobe tick_os every div_active
// cycles, slow strobe tick every OS_RATIO fast strobes, periodic or one-shot.
module tick_gen_prog #(
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 6_250_000,
    parameter int          OS_RATIO    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             oneshot,
    input  logic             start,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick_os,
    output logic             tick,
    output logic             busy,
    output logic             div_err,
    output logic [CNT_W-1:0] cnt_value
);

    localparam int OS_W = (OS_RATIO > 2) ? $clog2(OS_RATIO) : 1;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS_RATIO - 1);

    typedef enum logic {MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1} mode_t;

    mode_t            mode;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_shadow;
    logic [OS_W-1:0]  os_cnt;
    logic             pending;

    logic run, wrap, load_ok, last_os, apply;

    assign run     = en && (mode == MODE_PERIODIC || busy);
    // >= keeps the wrap safe if a smaller divisor lands while cnt is held high
    assign wrap    = run && !clr && (cnt >= div_active - CNT_W'(1));
    assign load_ok = div_load && (div_in >= CNT_W'(2));
    assign last_os = (os_cnt == OS_LAST);
    assign apply   = wrap || !run;

    assign cnt_value = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            os_cnt     <= '0;
            div_active <= DIV_RST;
            div_shadow <= DIV_RST;
            pending    <= 1'b0;
            mode       <= MODE_PERIODIC;
            busy       <= 1'b0;
            tick_os    <= 1'b0;
            tick       <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            tick_os <= 1'b0;
            tick    <= 1'b0;
            div_err <= div_load && !load_ok;

            // Mode only follows the input between runs so a run never changes mode
            if (cnt == '0 && os_cnt == '0 && !busy)
                mode <= mode_t'(oneshot);

            if (clr) begin
                cnt    <= '0;
                os_cnt <= '0;
                busy   <= 1'b0;
            end else begin
                if (wrap) begin
                    cnt     <= '0;
                    tick_os <= 1'b1;
                    if (last_os) begin
                        os_cnt <= '0;
                        tick   <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end else if (run) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (start && mode == MODE_ONESHOT && !busy)
                    busy <= 1'b1;
            end

            // Divisor changes only at a period boundary or while stopped
            if (apply && load_ok) begin
                div_active <= div_in;
                pending    <= 1'b0;
            end else if (apply && pending) begin
                div_active <= div_shadow;
                pending    <= 1'b0;
            end else if (load_ok) begin
                pending <= 1'b1;
            end
            if (load_ok)
                div_shadow <= div_in;
        end
    end

endmodule

// File: tb/tb_tick_gen_prog.sv
// Bench for tick_gen_prog: directed scenarios with literal timings plus random
// stimulus, all checked every cycle against a behavioural model.
module tb_tick_gen_prog;

    localparam int CW   = 16;
    localparam int DDIV = 4;
    localparam int OSR  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, clr = 1'b0, oneshot = 1'b0, start = 1'b0, div_load = 1'b0;
    logic [CW-1:0] div_in = '0;
    logic          tick_os, tick, busy, div_err;
    logic [CW-1:0] cnt_value;

    tick_gen_prog #(.CNT_W(CW), .DEFAULT_DIV(DDIV), .OS_RATIO(OSR)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .oneshot(oneshot), .start(start),
        .div_load(div_load), .div_in(div_in), .tick_os(tick_os), .tick(tick),
        .busy(busy), .div_err(div_err), .cnt_value(cnt_value)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycn  = 0;
    bit armed = 0;
    int tos_q[$];
    int tk_q[$];
    int err_n  = 0;
    int busy_n = 0;

    // Behavioural model state
    int m_cnt, m_wraps, m_div, m_shadow;
    bit m_pend, m_mode, m_busy, m_tos, m_tick, m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cycn);
        end
    endtask

    // One clock edge of the block as described: figure out whether this edge
    // ends a period, then update mode, run state and divisor from pre-edge values.
    task automatic model_step();
        bit run, wrap, ok, old_busy, old_mode, idle;
        if (rst) begin
            m_cnt = 0; m_wraps = 0; m_div = DDIV; m_shadow = DDIV;
            m_pend = 0; m_mode = 0; m_busy = 0; m_tos = 0; m_tick = 0; m_err = 0;
            return;
        end
        old_busy = m_busy;
        old_mode = m_mode;
        idle     = (m_cnt == 0 && m_wraps == 0 && !m_busy);
        run      = en && (!m_mode || m_busy);
        ok       = div_load && int'(div_in) >= 2;
        wrap     = run && !clr && (m_cnt >= m_div - 1);
        m_tos    = wrap;
        m_tick   = wrap && (m_wraps == OSR - 1);
        m_err    = div_load && !ok;
        if (clr) begin
            m_cnt = 0; m_wraps = 0; m_busy = 0;
        end else begin
            if (wrap) begin
                m_cnt   = 0;
                m_wraps = (m_wraps + 1) % OSR;
                if (m_tick) m_busy = 0;
            end else if (run) begin
                m_cnt++;
            end
            if (start && old_mode && !old_busy) m_busy = 1;
        end
        if (wrap || !run) begin
            if (ok) m_div = int'(div_in);
            else if (m_pend) m_div = m_shadow;
            m_pend = 0;
        end else if (ok) begin
            m_pend = 1;
        end
        if (ok) m_shadow = int'(div_in);
        if (idle) m_mode = oneshot;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cycn++;
            model_step();
            @(negedge clk);
            if (armed) begin
                chk("tick_os", tick_os, m_tos);
                chk("tick", tick, m_tick);
                chk("busy", busy, m_busy);
                chk("div_err", div_err, m_err);
                chk("cnt_value", cnt_value, m_cnt);
                if (tick_os) tos_q.push_back(cycn);
                if (tick) tk_q.push_back(cycn);
                if (div_err) err_n++;
                if (busy) busy_n++;
            end
            if (rst) armed = 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_ev();
        tos_q.delete(); tk_q.delete(); err_n = 0; busy_n = 0;
    endtask

    task automatic do_reset(input bit en_v, input bit os_v);
        rst = 1; en = en_v; oneshot = os_v; clr = 0; start = 0; div_load = 0;
        cyc(2);
        rst = 0;
    endtask

    task automatic oneshot_run(input string nm, input bit mid_start);
        int base;
        start = 1; base = cycn; clear_ev();
        cyc(1); start = 0;
        if (mid_start) begin
            cyc(4); start = 1; cyc(1); start = 0; cyc(20);
        end else begin
            cyc(25);
        end
        chk({nm, "_ticks"}, tk_q.size(), 1);
        chk({nm, "_tick_at"}, tk_q.size() > 0 ? tk_q[0] - base : -1, 17);
        chk({nm, "_busy_len"}, busy_n, 16);
        chk({nm, "_tos_n"}, tos_q.size(), 4);
        chk({nm, "_end_cnt"}, cnt_value, 0);
    endtask

    initial begin
        int base;
        bit found;
        // reset state
        cyc(2);
        chk("rst_cnt", cnt_value, 0);
        chk("rst_tos", tick_os, 0);
        chk("rst_busy", busy, 0);

        // Periodic from reset release
        en = 1; rst = 0; base = cycn; clear_ev();
        cyc(40);
        chk("p1_first_tos", tos_q.size() > 0 ? tos_q[0] - base : -1, 4);
        for (int i = 0; i < 3; i++)
            chk($sformatf("p1_tos_per%0d", i), tos_q.size() > i + 1 ? tos_q[i+1] - tos_q[i] : -1, 4);
        chk("p1_first_tick", tk_q.size() > 0 ? tk_q[0] - base : -1, 16);
        chk("p1_tick_per", tk_q.size() > 1 ? tk_q[1] - tk_q[0] : -1, 16);

        // Load 6 at cnt==1
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cnt_value == 1) found = 1;
            else cyc(1);
        end
        chk("p2_wait_cnt1", found, 1);
        div_load = 1; div_in = 6; base = cycn; clear_ev();
        cyc(1); div_load = 0;
        cyc(40);
        chk("p2_tos_n", tos_q.size(), 7);
        chk("p2_first_tos", tos_q.size() > 0 ? tos_q[0] - base : -1, 3);
        for (int i = 0; i < 6; i++)
            chk($sformatf("p2_per%0d", i), tos_q.size() > i + 1 ? tos_q[i+1] - tos_q[i] : -1, 6);

        // Illegal loads
        do_reset(1, 0);
        base = cycn; clear_ev();
        div_load = 1; div_in = 1; cyc(1);
        div_in = 0; cyc(1);
        div_load = 0; cyc(30);
        chk("p3_err_n", err_n, 2);
        chk("p3_first_tos", tos_q.size() > 0 ? tos_q[0] - base : -1, 4);
        chk("p3_per", tos_q.size() > 3 ? tos_q[3] - tos_q[2] : -1, 4);

        // One-shot runs
        do_reset(0, 1);
        cyc(2); en = 1; cyc(2);
        oneshot_run("p4a", 1);
        oneshot_run("p4b", 0);

        // Pause at cnt=2, one wrap done
        do_reset(1, 0);
        cyc(6);
        chk("p5_cnt_before", cnt_value, 2);
        en = 0; clear_ev(); cyc(5);
        chk("p5_cnt_held", cnt_value, 2);
        chk("p5_no_tos", tos_q.size(), 0);
        chk("p5_no_tick", tk_q.size(), 0);
        en = 1; base = cycn; cyc(10);
        chk("p5_resume_tos", tos_q.size() > 0 ? tos_q[0] - base : -1, 2);

        // Reset mid one-shot with divisor 9 pending
        do_reset(0, 1);
        cyc(2); en = 1; cyc(1);
        start = 1; cyc(1); start = 0;
        div_load = 1; div_in = 9; cyc(1); div_load = 0; cyc(1);
        chk("p6_busy_pre", busy, 1);
        rst = 1; cyc(1);
        chk("p6_busy", busy, 0);
        chk("p6_tick", tick, 0);
        chk("p6_tos", tick_os, 0);
        chk("p6_cnt", cnt_value, 0);
        rst = 0; oneshot = 0; base = cycn; clear_ev();
        cyc(30);
        chk("p6_first_tos", tos_q.size() > 0 ? tos_q[0] - base : -1, 4);
        chk("p6_per", tos_q.size() > 2 ? tos_q[2] - tos_q[1] : -1, 4);

        // clr while os_cnt==3
        do_reset(1, 0);
        cyc(13);
        clr = 1; base = cycn; clear_ev(); cyc(1); clr = 0;
        chk("p7_cnt_clr", cnt_value, 0);
        cyc(20);
        chk("p7_tick_at", tk_q.size() > 0 ? tk_q[0] - base : -1, 17);

        // Random traffic against the model
        do_reset(1, 0);
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom % 8) != 0;
            clr      = ($urandom % 64) == 0;
            div_load = ($urandom % 16) == 0;
            div_in   = CW'($urandom_range(0, 9));
            start    = ($urandom % 8) == 0;
            if (($urandom % 100) == 0) oneshot = ~oneshot;
            rst      = ($urandom % 500) == 0;
            cyc(1);
        end
        rst = 0; en = 0; clr = 0; div_load = 0; start = 0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
